// File: rtl/led_breather.sv
// Breathing LED: each blink transition steps a brightness level along a triangle
// ramp, and a free-running PWM counter turns that level into a dimmed LED drive.
module led_breather #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_blink,
    input  logic                io_enable,
    output logic                io_led,
    output logic [PWM_BITS-1:0] io_level,
    output logic                io_dir
);

    localparam int                  MAX       = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS:0]   MAX_W     = (PWM_BITS + 1)'(MAX);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    generate
        if (STEP < 1 || STEP > MAX) begin : g_bad_step
            $error("led_breather: STEP must lie in 1..2^PWM_BITS-1");
        end
    endgenerate

    logic                blink_q, blink_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                dir_q, dir_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                led_q, led_d;

    logic                blink_edge;
    logic [PWM_BITS:0]   level_ext;
    logic [PWM_BITS:0]   level_sum;

    // Both blink polarities count as a step; the extra bit keeps the sum from wrapping.
    always_comb begin
        blink_edge = io_blink ^ blink_q;
        level_ext  = {1'b0, level_q};
        level_sum  = level_ext + STEP_W;
        blink_d    = io_blink;
        level_d    = level_q;
        dir_d      = dir_q;
        if (blink_edge && io_enable) begin
            if (!dir_q) begin
                if (level_sum >= MAX_W) begin
                    level_d = LEVEL_MAX;
                    dir_d   = 1'b1;
                end else begin
                    level_d = level_sum[PWM_BITS-1:0];
                end
            end else begin
                if (level_ext <= STEP_W) begin
                    level_d = '0;
                    dir_d   = 1'b0;
                end else begin
                    level_d = level_q - STEP_W[PWM_BITS-1:0];
                end
            end
        end
    end

    // Full level is forced on so MAX really means 100% duty, not MAX/(MAX+1).
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        led_d     = io_enable && ((pwm_cnt_q < level_q) || (level_q == LEVEL_MAX));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_q   <= 1'b0;
            level_q   <= '0;
            dir_q     <= 1'b0;
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            blink_q   <= blink_d;
            level_q   <= level_d;
            dir_q     <= dir_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign io_led   = led_q;
    assign io_level = level_q;
    assign io_dir   = dir_q;

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather: ramp, duty, enable gating and corner cases on
// three instances (STEP = 16, 255 and 40) with a queue of expected level/dir results.
module tb_led_breather;

    logic       clock = 1'b0;
    logic       reset;
    logic       blink_a, en_a, blink_b, en_b;
    logic       led_a, dir_a, led_b, dir_b, led_c, dir_c;
    logic [7:0] lvl_a, lvl_b, lvl_c;

    int vectors     = 0;
    int miscompares = 0;
    int cur_a       = 0;

    typedef struct {
        int         unit;
        logic [7:0] level;
        logic       dir;
    } exp_t;
    exp_t sb_q[$];

    always #5 clock = ~clock;

    led_breather u_dut (
        .clock(clock), .reset(reset), .io_blink(blink_a), .io_enable(en_a),
        .io_led(led_a), .io_level(lvl_a), .io_dir(dir_a)
    );

    led_breather #(.STEP(255)) u_dut255 (
        .clock(clock), .reset(reset), .io_blink(blink_b), .io_enable(en_b),
        .io_led(led_b), .io_level(lvl_b), .io_dir(dir_b)
    );

    led_breather #(.STEP(40)) u_dut40 (
        .clock(clock), .reset(reset), .io_blink(blink_b), .io_enable(en_b),
        .io_led(led_c), .io_level(lvl_c), .io_dir(dir_c)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int unit, input int lvl, input logic dir);
        exp_t e;
        e.unit  = unit;
        e.level = 8'(lvl);
        e.dir   = dir;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t       e;
        logic [7:0] ol;
        logic       od;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.unit)
                0:       begin ol = lvl_a; od = dir_a; end
                1:       begin ol = lvl_b; od = dir_b; end
                default: begin ol = lvl_c; od = dir_c; end
            endcase
            chk($sformatf("%s_u%0d_level", tag, e.unit), {24'd0, ol}, {24'd0, e.level});
            chk($sformatf("%s_u%0d_dir", tag, e.unit), {31'd0, od}, {31'd0, e.dir});
        end
    endtask

    // One blink step on the STEP=16 instance; level must hold until the clock after the edge.
    task automatic step_a(input string tag, input bit toggle, input int lvl, input logic dir);
        chk({tag, "_hold"}, {24'd0, lvl_a}, cur_a);
        if (toggle) blink_a = ~blink_a;
        push(0, lvl, dir);
        tick();
        drain(tag);
        cur_a = lvl;
    endtask

    task automatic duty(input string tag, input int exp);
        int cnt = 0;
        repeat (256) begin
            tick();
            if (led_a === 1'b1) cnt++;
        end
        chk(tag, cnt, exp);
    endtask

    initial begin
        reset = 1'b1; en_a = 1'b1; blink_a = 1'b0; en_b = 1'b0; blink_b = 1'b0;

        for (int i = 0; i < 3; i++) begin
            blink_a = ~blink_a;
            tick();
            chk("rst_led", {31'd0, led_a}, 0);
            chk("rst_level", {24'd0, lvl_a}, 0);
            chk("rst_dir", {31'd0, dir_a}, 0);
        end
        reset = 1'b0;
        chk("rel_led", {31'd0, led_a}, 0);
        chk("rel_level", {24'd0, lvl_a}, 0);
        chk("rel_dir", {31'd0, dir_a}, 0);

        // io_blink is already 1 against a reset blink_q, so the first step needs no toggle.
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) repeat (9) tick();
            step_a($sformatf("rise%0d", i), i > 1, (i < 16) ? 16 * i : 255, i == 16);
        end

        for (int i = 1; i <= 16; i++) begin
            repeat (9) tick();
            step_a($sformatf("fall%0d", i), 1'b1, (i < 16) ? 255 - 16 * i : 0, i < 16);
        end

        duty("duty_level0", 0);
        for (int i = 1; i <= 4; i++) begin
            repeat (2) tick();
            step_a($sformatf("to64_%0d", i), 1'b1, 16 * i, 1'b0);
        end
        duty("duty_level64", 64);
        for (int i = 5; i <= 8; i++) begin
            repeat (2) tick();
            step_a($sformatf("to128_%0d", i), 1'b1, 16 * i, 1'b0);
        end

        en_a = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) repeat (3) tick();
            step_a($sformatf("gated%0d", i), 1'b1, 128, 1'b0);
            chk($sformatf("gated%0d_led", i), {31'd0, led_a}, 0);
        end
        en_a = 1'b1;
        repeat (5) tick();
        chk("reen_static_level", {24'd0, lvl_a}, 128);
        step_a("reen_step", 1'b1, 144, 1'b0);

        for (int i = 1; i <= 7; i++) begin
            repeat (2) tick();
            step_a($sformatf("to255_%0d", i), 1'b1, (i < 7) ? 144 + 16 * i : 255, i == 7);
        end
        duty("duty_level255", 256);

        // Enable rises in the same cycle as the first edge: the step is applied.
        en_b = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) repeat (3) tick();
            blink_b = ~blink_b;
            push(1, (k % 2 == 1) ? 255 : 0, k % 2 == 1);
            push(2, 40 * k, 1'b0);
            tick();
            drain($sformatf("corner%0d", k));
        end

        reset   = 1'b1;
        blink_b = ~blink_b;
        push(0, 0, 1'b0);
        push(1, 0, 1'b0);
        push(2, 0, 1'b0);
        tick();
        drain("rst_mid");
        chk("rst_mid_led", {31'd0, led_a}, 0);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
